htax_outport_arbiter: RTL and testbench

Per-output-port packet arbiter of the HTAX switch. It sits directly upstream of the output-port data mux. It collects per-inport, per-VC transfer requests and picks one inport/VC pair using two-level round-robin. It produces the one-hot `inport_sel` and the single-cycle `any_gnt` the mux consumes, and holds the selection until the granted inport signals end-of-transfer.

---
 rtl/htax_pkg.sv | 18 +
 rtl/htax_outport_arbiter_if.sv | 39 +++
 rtl/htax_rr_picker.sv | 39 +++
 rtl/htax_outport_arbiter.sv | 122 ++++++++++++
 tb/tb_htax_outport_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/htax_pkg.sv
// Shared HTAX definitions: switch-wide size defaults, the arbiter state
// encoding and a pointer-width helper used by the arbiter and the data mux.
package htax_pkg;

    localparam int HTAX_NUM_PORTS = 4;
    localparam int HTAX_VC        = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_e;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/htax_outport_arbiter_if.sv
// Request/grant bundle between the inports and one output-port arbiter.
// The master side raises requests and end-of-transfer; the slave side
// (the arbiter) returns grant pulses and the held inport/VC selection.
interface htax_outport_arbiter_if
    import htax_pkg::*;
#(
    parameter int NUM_PORTS = HTAX_NUM_PORTS,
    parameter int VC        = HTAX_VC
);

    logic [VC*NUM_PORTS-1:0] inport_req;
    logic [VC-1:0]           vc_ready;
    logic [NUM_PORTS-1:0]    eot_in;
    logic [VC*NUM_PORTS-1:0] inport_gnt;
    logic [NUM_PORTS-1:0]    inport_sel;
    logic                    any_gnt;
    logic [VC-1:0]           gnt_vc;

    modport master (
        output inport_req,
        output vc_ready,
        output eot_in,
        input  inport_gnt,
        input  inport_sel,
        input  any_gnt,
        input  gnt_vc
    );

    modport slave (
        input  inport_req,
        input  vc_ready,
        input  eot_in,
        output inport_gnt,
        output inport_sel,
        output any_gnt,
        output gnt_vc
    );

endinterface

// File: rtl/htax_rr_picker.sv
// Combinational round-robin picker: rotates the request vector so the
// pointer position comes first, takes the lowest set bit, and rotates the
// result back into a one-hot winner plus its index.
module htax_rr_picker
    import htax_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = ptrWidth(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    logic [N-1:0] rotated;
    int           firstPos;
    int           winPos;

    // Rotate, find the first requester after the pointer, rotate back.
    always_comb begin
        rotated  = N'({req_i, req_i} >> ptr_i);
        firstPos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                firstPos = k;
            end
        end
        winPos = firstPos + int'(ptr_i);
        if (winPos >= N) begin
            winPos = winPos - N;
        end
        valid_o = |req_i;
        idx_o   = W'(winPos);
        gnt_o   = valid_o ? (N'(1) << winPos) : '0;
    end

endmodule

// File: rtl/htax_outport_arbiter.sv
// Output-port arbiter: two-level round-robin (VC first, then inport within
// the VC) with registered grant pulse and a selection held until the
// granted inport signals end-of-transfer.
module htax_outport_arbiter
    import htax_pkg::*;
#(
    parameter int NUM_PORTS = HTAX_NUM_PORTS,
    parameter int VC        = HTAX_VC
) (
    input  logic                   clk,
    input  logic                   res,
    htax_outport_arbiter_if.slave  arb
);

    localparam int PW = ptrWidth(NUM_PORTS);
    localparam int VW = ptrWidth(VC);

    arbState_e                      state_q;
    logic [VC*NUM_PORTS-1:0]        inportGnt_q;
    logic                           anyGnt_q;
    logic [NUM_PORTS-1:0]           inportSel_q;
    logic [VC-1:0]                  gntVc_q;
    logic [VW-1:0]                  vcPtr_q;
    logic [VC-1:0][PW-1:0]          portPtr_q;

    logic [VC-1:0][NUM_PORTS-1:0]   portReq;
    logic [VC-1:0][NUM_PORTS-1:0]   portGnt;
    logic [VC-1:0][PW-1:0]          portIdx;
    logic [VC-1:0]                  vcHasReq;
    logic [VC-1:0]                  vcGnt;
    logic [VW-1:0]                  vcIdx;
    logic                           vcValid;

    logic [PW-1:0]                  winPort;
    logic [NUM_PORTS-1:0]           winSel;
    logic [VC*NUM_PORTS-1:0]        inportGnt_d;
    logic [VW-1:0]                  vcPtr_d;
    logic [PW-1:0]                  portPtr_d;

    // Regroup the flat request bus per VC, masking VCs with no downstream room.
    always_comb begin
        portReq = '0;
        for (int v = 0; v < VC; v++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                portReq[v][i] = arb.inport_req[i*VC + v] & arb.vc_ready[v];
            end
        end
    end

    for (genvar v = 0; v < VC; v++) begin : g_portPick
        htax_rr_picker #(.N(NUM_PORTS)) u_portPicker (
            .req_i   (portReq[v]),
            .ptr_i   (portPtr_q[v]),
            .gnt_o   (portGnt[v]),
            .idx_o   (portIdx[v]),
            .valid_o (vcHasReq[v])
        );
    end

    htax_rr_picker #(.N(VC)) u_vcPicker (
        .req_i   (vcHasReq),
        .ptr_i   (vcPtr_q),
        .gnt_o   (vcGnt),
        .idx_o   (vcIdx),
        .valid_o (vcValid)
    );

    // Combine the winning VC with its inport winner and prepare the pointer advances.
    always_comb begin
        winPort     = portIdx[vcIdx];
        winSel      = portGnt[vcIdx];
        inportGnt_d = '0;
        inportGnt_d[int'(winPort)*VC + int'(vcIdx)] = 1'b1;
        vcPtr_d     = (int'(vcIdx) == VC - 1) ? '0 : vcIdx + VW'(1);
        portPtr_d   = (int'(winPort) == NUM_PORTS - 1) ? '0 : winPort + PW'(1);
    end

    // Arbiter FSM: grant from IDLE, hold the selection in BUSY until the owner's eot.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            inportGnt_q <= '0;
            anyGnt_q    <= 1'b0;
            inportSel_q <= '0;
            gntVc_q     <= '0;
            vcPtr_q     <= '0;
            portPtr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vcValid) begin
                        inportGnt_q       <= inportGnt_d;
                        anyGnt_q          <= 1'b1;
                        inportSel_q       <= winSel;
                        gntVc_q           <= vcGnt;
                        vcPtr_q           <= vcPtr_d;
                        portPtr_q[vcIdx]  <= portPtr_d;
                        state_q           <= BUSY;
                    end else begin
                        inportGnt_q <= '0;
                        anyGnt_q    <= 1'b0;
                    end
                end
                BUSY: begin
                    inportGnt_q <= '0;
                    anyGnt_q    <= 1'b0;
                    if (!anyGnt_q && |(arb.eot_in & inportSel_q)) begin
                        inportSel_q <= '0;
                        gntVc_q     <= '0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign arb.inport_gnt = inportGnt_q;
    assign arb.any_gnt    = anyGnt_q;
    assign arb.inport_sel = inportSel_q;
    assign arb.gnt_vc     = gntVc_q;

endmodule

// File: tb/tb_htax_outport_arbiter.sv
// Testbench for htax_outport_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural arbitration model.
module tb_htax_outport_arbiter;
    import htax_pkg::*;

    localparam int NP = 4;
    localparam int NV = 2;

    logic clk = 1'b0;
    logic res;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int          mVcPtr = 0;
    int          mPortPtr [NV] = '{default: 0};
    bit          mBusy = 1'b0;
    bit          mGrantCycle = 1'b0;
    int          mSelPort = 0;
    logic [7:0]  expGnt = '0;
    logic [3:0]  expSel = '0;
    logic        expAny = 1'b0;
    logic [1:0]  expVc = '0;

    htax_outport_arbiter_if #(.NUM_PORTS(NP), .VC(NV)) arbIf ();

    htax_outport_arbiter #(.NUM_PORTS(NP), .VC(NV)) dut (
        .clk (clk),
        .res (res),
        .arb (arbIf.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge from the inputs it sees at that edge.
    task automatic modelStep();
        bit found;
        int winV;
        int winP;
        int v;
        int p;
        found = 1'b0;
        winV  = 0;
        winP  = 0;
        if (res) begin
            mVcPtr      = 0;
            mPortPtr    = '{default: 0};
            mBusy       = 1'b0;
            mGrantCycle = 1'b0;
            expGnt = '0; expSel = '0; expAny = 1'b0; expVc = '0;
        end else if (!mBusy) begin
            for (int k = 0; k < NV && !found; k++) begin
                v = (mVcPtr + k) % NV;
                if (arbIf.vc_ready[v]) begin
                    for (int j = 0; j < NP && !found; j++) begin
                        p = (mPortPtr[v] + j) % NP;
                        if (arbIf.inport_req[p*NV + v]) begin
                            found = 1'b1;
                            winV  = v;
                            winP  = p;
                        end
                    end
                end
            end
            if (found) begin
                expGnt         = 8'(1 << (winP*NV + winV));
                expAny         = 1'b1;
                expSel         = 4'(1 << winP);
                expVc          = 2'(1 << winV);
                mVcPtr         = (winV + 1) % NV;
                mPortPtr[winV] = (winP + 1) % NP;
                mBusy          = 1'b1;
                mGrantCycle    = 1'b1;
                mSelPort       = winP;
            end else begin
                expGnt = '0; expAny = 1'b0;
            end
        end else begin
            expGnt = '0;
            expAny = 1'b0;
            if (!mGrantCycle && arbIf.eot_in[mSelPort]) begin
                expSel = '0;
                expVc  = '0;
                mBusy  = 1'b0;
            end
            mGrantCycle = 1'b0;
        end
    endtask

    task automatic checkOutput();
        checkVal("model_gnt", 32'(arbIf.inport_gnt), 32'(expGnt));
        checkVal("model_sel", 32'(arbIf.inport_sel), 32'(expSel));
        checkVal("model_any", 32'(arbIf.any_gnt),    32'(expAny));
        checkVal("model_vc",  32'(arbIf.gnt_vc),     32'(expVc));
    endtask

    // Drive one cycle of inputs (away from the edge), step the model, check after the edge.
    task automatic applyStimulus(input logic [7:0] req, input logic [1:0] rdy,
                                 input logic [3:0] eot, input logic rst);
        res                = rst;
        arbIf.inport_req   = req;
        arbIf.vc_ready     = rdy;
        arbIf.eot_in       = eot;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkGrant(input string tag, input logic [7:0] gnt, input logic [3:0] sel,
                              input logic any, input logic [1:0] vc);
        checkVal({tag, "_gnt"}, 32'(arbIf.inport_gnt), 32'(gnt));
        checkVal({tag, "_sel"}, 32'(arbIf.inport_sel), 32'(sel));
        checkVal({tag, "_any"}, 32'(arbIf.any_gnt),    32'(any));
        checkVal({tag, "_vc"},  32'(arbIf.gnt_vc),     32'(vc));
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        logic [7:0] rReq;
        logic [1:0] rRdy;
        logic [3:0] rEot;
        logic       rRst;
        int         p;

        res = 1'b1;
        arbIf.inport_req = '0;
        arbIf.vc_ready   = '0;
        arbIf.eot_in     = '0;

        // Reset held two cycles with every request raised
        applyStimulus(8'hFF, 2'b11, 4'b0000, 1'b1);
        applyStimulus(8'hFF, 2'b11, 4'b0000, 1'b1);
        checkGrant("reset", 8'h00, 4'b0000, 1'b0, 2'b00);
        applyStimulus(8'hFF, 2'b11, 4'b0000, 1'b0);
        checkGrant("first_grant", 8'h01, 4'b0001, 1'b1, 2'b01);

        // Mid-packet events must not disturb the held selection
        applyStimulus(8'h00, 2'b11, 4'b1111, 1'b0);
        checkGrant("eot_in_gnt_cycle", 8'h00, 4'b0001, 1'b0, 2'b01);
        applyStimulus(8'h00, 2'b11, 4'b1110, 1'b0);
        checkGrant("eot_other_port", 8'h00, 4'b0001, 1'b0, 2'b01);
        applyStimulus(8'hFF, 2'b00, 4'b0000, 1'b0);
        checkGrant("vc_ready_drop", 8'h00, 4'b0001, 1'b0, 2'b01);
        applyStimulus(8'h00, 2'b11, 4'b0001, 1'b0);
        checkGrant("release", 8'h00, 4'b0000, 1'b0, 2'b00);

        // Single packet from inport 1 on VC 0, eot three cycles after grant
        applyStimulus(8'h04, 2'b11, 4'b0000, 1'b0);
        checkGrant("single_grant", 8'h04, 4'b0010, 1'b1, 2'b01);
        applyStimulus(8'h00, 2'b11, 4'b0000, 1'b0);
        applyStimulus(8'h00, 2'b11, 4'b0000, 1'b0);
        checkGrant("single_hold", 8'h00, 4'b0010, 1'b0, 2'b01);
        applyStimulus(8'h00, 2'b11, 4'b0010, 1'b0);
        checkGrant("single_release", 8'h00, 4'b0000, 1'b0, 2'b00);

        // Fairness: all inports on VC 0, one-flit packets
        applyStimulus(8'h55, 2'b11, 4'b0000, 1'b1);
        for (int n = 0; n < 5; n++) begin
            p = n % 4;
            applyStimulus(8'h55, 2'b11, 4'b0000, 1'b0);
            checkGrant("fair_grant", 8'(1 << (2*p)), 4'(1 << p), 1'b1, 2'b01);
            applyStimulus(8'h55, 2'b11, 4'b0000, 1'b0);
            applyStimulus(8'h55, 2'b11, 4'(1 << p), 1'b0);
            checkGrant("fair_bubble", 8'h00, 4'b0000, 1'b0, 2'b00);
        end

        // VC alternation on inport 0, then backpressure on VC 1
        applyStimulus(8'h03, 2'b11, 4'b0000, 1'b1);
        for (int n = 0; n < 5; n++) begin
            rRdy = (n < 3) ? 2'b11 : 2'b01;
            applyStimulus(8'h03, rRdy, 4'b0000, 1'b0);
            if (n == 1) begin
                checkGrant("vc_alt", 8'h02, 4'b0001, 1'b1, 2'b10);
            end else begin
                checkGrant("vc_alt", 8'h01, 4'b0001, 1'b1, 2'b01);
            end
            applyStimulus(8'h03, rRdy, 4'b0000, 1'b0);
            applyStimulus(8'h03, rRdy, 4'b0001, 1'b0);
        end

        // Reset in the middle of a packet from inport 2
        applyStimulus(8'h10, 2'b11, 4'b0000, 1'b0);
        checkGrant("mid_grant", 8'h10, 4'b0100, 1'b1, 2'b01);
        applyStimulus(8'h10, 2'b11, 4'b0000, 1'b0);
        applyStimulus(8'hFF, 2'b11, 4'b0000, 1'b1);
        checkGrant("mid_reset", 8'h00, 4'b0000, 1'b0, 2'b00);
        applyStimulus(8'hFF, 2'b11, 4'b0000, 1'b0);
        checkGrant("ptr_after_reset", 8'h01, 4'b0001, 1'b1, 2'b01);
        applyStimulus(8'h00, 2'b11, 4'b0000, 1'b0);
        applyStimulus(8'h00, 2'b11, 4'b0001, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rReq = 8'($urandom);
            rRdy = 2'($urandom);
            rEot = 4'($urandom);
            rRst = ($urandom_range(0, 49) == 0);
            applyStimulus(rReq, rRdy, rEot, rRst);
        end

        $display("[TB] directed and random phases complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
